// File: rtl/led_breather_if.sv
// Signal bundle between the board top level and the breathing-LED block.
// The board side (master) supplies Enable and Counter; the breather (slave) returns the LED state.
interface led_breather_if #(
   parameter int COUNTER_WIDTH = 32,
   parameter int PWM_BITS      = 8
);
   logic                     Enable;
   logic [COUNTER_WIDTH-1:0] Counter;
   logic                     Led;
   logic [PWM_BITS-1:0]      Duty;
   logic [1:0]               Phase;

   modport master (output Enable, output Counter, input Led, input Duty, input Phase);
   modport slave  (input Enable, input Counter, output Led, output Duty, output Phase);
endinterface

// File: rtl/led_breather.sv
// Breathing LED: ramps a PWM duty up, holds, ramps down, holds, one step per
// rising edge of a chosen bit of the free-running counter.
module led_breather #(
   parameter int COUNTER_WIDTH = 32,
   parameter int TICK_BIT      = 10,
   parameter int PWM_BITS      = 8,
   parameter int HOLD_TICKS    = 16
) (
   input logic           Clock,
   input logic           Reset,
   led_breather_if.slave bus
);

   localparam int                 HOLD_W    = $clog2(HOLD_TICKS + 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      RAMP_UP   = 2'd0,
      HOLD_HIGH = 2'd1,
      RAMP_DOWN = 2'd2,
      HOLD_LOW  = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [PWM_BITS-1:0] duty_reg, duty_next;
   logic [HOLD_W-1:0]   hold_reg, hold_next;
   logic                prev_reg;
   logic                led_reg, led_next;
   logic                tick;
   logic                step;

   // The edge detector samples every cycle, so ticks seen while disabled are simply lost.
   assign tick = bus.Counter[TICK_BIT] & ~prev_reg;
   assign step = tick & bus.Enable;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_reg <= RAMP_UP;
         duty_reg  <= '0;
         hold_reg  <= '0;
         prev_reg  <= 1'b0;
         led_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         duty_reg  <= duty_next;
         hold_reg  <= hold_next;
         prev_reg  <= bus.Counter[TICK_BIT];
         led_reg   <= led_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      duty_next  = duty_reg;
      hold_next  = hold_reg;
      led_next   = bus.Enable & (bus.Counter[PWM_BITS-1:0] < duty_reg);

      if (step) begin
         case (state_reg)
            RAMP_UP: begin
               if (duty_reg == DUTY_MAX - DUTY_ONE) begin
                  duty_next  = DUTY_MAX;
                  hold_next  = '0;
                  state_next = HOLD_HIGH;
               end else if (duty_reg != DUTY_MAX) begin
                  duty_next = duty_reg + DUTY_ONE;
               end
            end
            HOLD_HIGH: begin
               if (hold_reg == HOLD_LAST) begin
                  state_next = RAMP_DOWN;
               end else begin
                  hold_next = hold_reg + HOLD_ONE;
               end
            end
            RAMP_DOWN: begin
               if (duty_reg == DUTY_ONE) begin
                  duty_next  = '0;
                  hold_next  = '0;
                  state_next = HOLD_LOW;
               end else if (duty_reg != '0) begin
                  duty_next = duty_reg - DUTY_ONE;
               end
            end
            HOLD_LOW: begin
               if (hold_reg == HOLD_LAST) begin
                  state_next = RAMP_UP;
               end else begin
                  hold_next = hold_reg + HOLD_ONE;
               end
            end
            default: state_next = RAMP_UP;
         endcase
      end
   end

   assign bus.Led   = led_reg;
   assign bus.Duty  = duty_reg;
   assign bus.Phase = state_reg;

endmodule

// File: tb/tb_led_breather.sv
// Randomized check of led_breather against a model that derives duty and phase
// purely from how many enabled ticks have elapsed within one breath.
module tb_led_breather;

   localparam int MAXD   = 255;
   localparam int HOLD   = 16;
   localparam int BREATH = 2 * MAXD + 2 * HOLD;

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   led_breather_if #(.COUNTER_WIDTH(32), .PWM_BITS(8)) bus ();

   led_breather #(
      .COUNTER_WIDTH(32),
      .TICK_BIT     (10),
      .PWM_BITS     (8),
      .HOLD_TICKS   (HOLD)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clock = ~Clock;

   int   total = 0;
   int   bad   = 0;
   int   m_k;        // enabled ticks since reset, modulo one breath
   int   m_ticks;
   logic m_prev;
   logic m_led;

   function automatic int ref_duty(input int k);
      if (k < MAXD)                    return k;
      else if (k < MAXD + HOLD)        return MAXD;
      else if (k < 2 * MAXD + HOLD)    return MAXD - (k - (MAXD + HOLD));
      else                             return 0;
   endfunction

   function automatic int ref_phase(input int k);
      if (k < MAXD)                    return 0;
      else if (k < MAXD + HOLD)        return 1;
      else if (k < 2 * MAXD + HOLD)    return 2;
      else                             return 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_led"},   32'(bus.Led),   32'(m_led));
      check({tag, "_duty"},  32'(bus.Duty),  32'(ref_duty(m_k)));
      check({tag, "_phase"}, 32'(bus.Phase), 32'(ref_phase(m_k)));
   endtask

   task automatic model_reset();
      m_k    = 0;
      m_prev = 1'b0;
      m_led  = 1'b0;
   endtask

   // Drive one clock's worth of inputs, advance the model, then compare after the edge.
   task automatic cycle(input string tag, input logic en, input logic [31:0] cnt);
      logic tick;
      bus.Enable  = en;
      bus.Counter = cnt;
      if (Reset) begin
         tick  = cnt[10] & ~m_prev;
         m_led = en && (int'(cnt[7:0]) < ref_duty(m_k));
         if (tick && en) begin
            m_k = (m_k + 1) % BREATH;
            m_ticks++;
         end
         m_prev = cnt[10];
      end
      @(negedge Clock);
      compare_all(tag);
   endtask

   initial begin
      int guard;
      bus.Enable  = 1'b0;
      bus.Counter = '0;
      m_ticks     = 0;
      model_reset();
      #1 Reset = 1'b0;

      repeat (20) cycle("reset_hold", 1'($urandom_range(0, 1)), $urandom);
      $display("reset hold: duty=%0d phase=%0d led=%0d", bus.Duty, bus.Phase, bus.Led);

      Reset = 1'b1;
      cycle("first_tick", 1'b1, 32'h0000_0400);
      $display("first tick after release: duty=%0d", bus.Duty);

      repeat (4000) cycle("random", 1'($urandom_range(0, 9) != 0), $urandom);
      $display("random run: ticks=%0d duty=%0d phase=%0d", m_ticks, bus.Duty, bus.Phase);

      repeat (60) cycle("disabled", 1'b0, $urandom);
      $display("disabled run: duty=%0d phase=%0d led=%0d", bus.Duty, bus.Phase, bus.Led);

      for (int i = 0; i < 256; i++) cycle("pwm_sweep", 1'b1, 32'(i));
      $display("pwm sweep at duty=%0d", bus.Duty);

      guard = 0;
      while (!(ref_phase(m_k) == 2 && ref_duty(m_k) < 220) && guard < 5000) begin
         cycle("to_ramp_down", 1'b1, $urandom);
         guard++;
      end
      check("reach_ramp_down", 32'(ref_phase(m_k)), 32'd2);
      $display("ramp down reached: duty=%0d phase=%0d", bus.Duty, bus.Phase);

      #2 Reset = 1'b0;
      model_reset();
      #1 compare_all("async_reset");
      $display("async reset mid-ramp: duty=%0d phase=%0d led=%0d", bus.Duty, bus.Phase, bus.Led);
      @(negedge Clock);
      repeat (5) cycle("reset_again", 1'b1, $urandom);

      Reset = 1'b1;
      repeat (600) cycle("post_reset", 1'($urandom_range(0, 7) != 0), $urandom);
      $display("post reset run: ticks=%0d duty=%0d phase=%0d", m_ticks, bus.Duty, bus.Phase);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_breather.md
# led_breather

Downstream consumer of the free-running 32-bit counter produced by the SimpleCounterModule top level on the TinyFPGA BX. It replaces the raw counter-bit LED blink with a "breathing" LED: it derives a slow tick from one counter bit, ramps a PWM duty cycle up and down through a four-phase state machine, and compares the duty against the counter's low bits to drive the LED pin. It sits between the counter module and the `LED` output in the board top level.

## Interface

Parameters:
- `COUNTER_WIDTH`, 32, width of the incoming counter bus.
- `TICK_BIT`, 10, counter bit whose rising edge produces one ramp tick; must be < `COUNTER_WIDTH`.
- `PWM_BITS`, 8, duty and PWM-compare width; must be ≤ `TICK_BIT`.
- `HOLD_TICKS`, 16, ticks spent at full and at zero brightness; ≥ 1.

Ports:
- `Clock`  in  1  system clock (16 MHz on board).
- `Reset`  in  1  asynchronous, active-low reset: asserted at 0, released at 1.
- `Enable`  in  1  1 = breathing runs; 0 = freeze phase/duty, LED off.
- `Counter`  in  `COUNTER_WIDTH`  free-running count from the counter module.
- `Led`  out  1  registered PWM output to the LED pin.
- `Duty`  out  `PWM_BITS`  current duty value (registered).
- `Phase`  out  2  current state: 0 RAMP_UP, 1 HOLD_HIGH, 2 RAMP_DOWN, 3 HOLD_LOW.

## Operation

- Reset (asynchronous, while `Reset`=0): `Led`=0, `Duty`=0, `Phase`=RAMP_UP, hold counter=0, tick-edge register=0.
- Tick: `tick` = `Counter[TICK_BIT]` & ~`prev`, where `prev` is `Counter[TICK_BIT]` registered every cycle regardless of `Enable`. If the bit is already 1 on the first clock after reset release, that cycle is a tick.
- State machine advances only when `tick` & `Enable`:
  - RAMP_UP: `Duty`+1. On the tick where `Duty` = max−1 (254 default): `Duty`←max, go HOLD_HIGH, hold counter←0.
  - HOLD_HIGH: hold counter+1; on the tick where hold counter = `HOLD_TICKS`−1: go RAMP_DOWN, `Duty` unchanged.
  - RAMP_DOWN: `Duty`−1. On the tick where `Duty` = 1: `Duty`←0, go HOLD_LOW, hold counter←0.
  - HOLD_LOW: as HOLD_HIGH, exits to RAMP_UP.
- `Duty` never wraps; it is saturated by construction (no increment at max, no decrement at 0).
- PWM: `Led` ← `Enable` & (`Counter[PWM_BITS-1:0]` < `Duty`), registered. `Duty`=0 gives LED always off; `Duty`=255 gives on 255 of 256 cycles.
- `Enable`=0: state, `Duty`, and hold counter hold; `Led` is forced to 0 on the next clock. Ticks occurring while disabled are discarded, not queued.
- Counter wrap-around (all ones → 0) needs no special handling; only the 0→1 transition of `TICK_BIT` counts.
- Reset asserted mid-ramp returns all state to reset values immediately, with no clock required.

## Timing

- Tick detected in cycle N (bit sampled 1, `prev` 0). `Duty`/`Phase` update at the clock edge ending cycle N and are visible in N+1.
- `Led` lags `Counter` and `Duty` by one clock: the value in N+1 reflects `Counter` and `Duty` as sampled in cycle N.
- Tick period: 2^(`TICK_BIT`+1) clocks (2048 default, 128 µs at 16 MHz).
- Full breath: 2·(2^`PWM_BITS`−1) + 2·`HOLD_TICKS` ticks (542 default, ≈69 ms).
- A single path only: a tick arriving in the same cycle as `Enable` rising is taken; a tick arriving in the same cycle as `Enable` falling is discarded.

## Test plan

- Reset: hold `Reset`=0 with `Counter` toggling -> `Led`=0, `Duty`=0, `Phase`=0 throughout; after release with `Enable`=1, the first `Counter[10]` 0→1 gives `Duty`=1 one cycle later.
- Ramp up: `Enable`=1, `Counter` incrementing by 1 per clock from 0 -> after 255 ticks `Duty`=255 and `Phase`=1; after 16 more ticks `Phase`=2 with `Duty` still 255.
- Full cycle: run 542 ticks from reset -> `Phase` returns to 0 with `Duty`=0; during HOLD_LOW `Led` is never 1; during HOLD_HIGH `Led` is 0 only when `Counter[7:0]`=255.
- PWM compare: force `Duty`=64 (run 64 ticks), sweep `Counter[7:0]` 0..255 -> `Led`=1 for exactly 64 consecutive cycles, each one clock after `Counter[7:0]` ∈ 0..63.
- Enable gating: drop `Enable` at `Duty`=100 for 10 tick periods -> `Led`=0 from the next clock, `Duty` stays 100, `Phase` stays 0; on re-enable the next tick gives `Duty`=101.
- Async reset mid-operation: assert `Reset`=0 between clock edges at `Duty`=200, `Phase`=2 -> `Duty`=0, `Phase`=0, and `Led`=0 before the next clock edge.
